// File: rtl/ai_paddle_sequencer.sv
// ai_paddle_sequencer: AI paddle controller (in CLOCK/RESET/ENABLE/BALL_H/BALL_V; out POSITION/TARGET/TRACKING/ARRIVED; optional AI_MISS_EN adds LFSR miss offset and MISSED)
module ai_paddle_sequencer #(
  parameter int NET_X       = 390,
  parameter int PADDLE_X    = 770,
  parameter int FIELD_H     = 474,
  parameter int PADDLE_HALF = 40,
  parameter int PADDLE_MAX  = 395,
  parameter int STEP_DIV    = 100000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic [10:0] BALL_H,
  input  logic [10:0] BALL_V,
  output logic [7:0]  POSITION,
  output logic [8:0]  TARGET,
  output logic        TRACKING,
`ifdef AI_MISS_EN
  output logic        MISSED,
`endif
  output logic        ARRIVED
);
  typedef enum logic [2:0] {IDLE, SAMPLE, PREDICT, MOVE, HOLD} state_t;
  localparam int CW = $clog2(STEP_DIV);
  localparam logic signed [12:0] D   = 13'(PADDLE_X - NET_X - 1);
  localparam logic signed [12:0] FH  = 13'(FIELD_H);
  localparam logic signed [12:0] FH2 = 13'(2 * FIELD_H);
  localparam logic signed [12:0] PH  = 13'(PADDLE_HALF);
  localparam logic signed [12:0] PM  = 13'(PADDLE_MAX);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [10:0] r_v0, r_v1;
  logic r_dir, r_tracking, r_arrived, w_tick, w_below;
  logic [8:0] r_paddle, r_target, w_clamp, w_tgt;
  logic signed [12:0] w_v1, w_y_dn, w_y, w_t;
  assign w_tick  = r_cnt == CW'(STEP_DIV - 1);
  assign w_below = BALL_H < 11'(NET_X);
  assign w_v1    = $signed({2'b0, r_v1});
  assign w_y_dn  = w_v1 + D;
  assign w_y     = r_dir ? ((w_y_dn > FH) ? FH2 - w_y_dn : w_y_dn) : ((D > w_v1) ? D - w_v1 : w_v1 - D);
  assign w_t     = w_y - PH;
  assign w_clamp = w_t[12] ? 9'd0 : (w_t > PM ? 9'(PADDLE_MAX) : w_t[8:0]);
`ifdef AI_MISS_EN
  logic [7:0] r_lfsr;
  logic r_missed, w_miss;
  assign w_miss = r_lfsr[7:5] == 3'b000;
  assign w_tgt  = !w_miss ? w_clamp : (w_clamp > 9'(PADDLE_MAX - 64) ? w_clamp - 9'd64 : w_clamp + 9'd64);
  assign MISSED = r_missed;
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_lfsr   <= 8'hA5;
      r_missed <= 1'b0;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      if (r_state == IDLE) r_missed <= 1'b0;
      else if (r_state == PREDICT && w_next == MOVE) r_missed <= w_miss;
    end
  end
`else
  assign w_tgt = w_clamp;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = BALL_H == 11'(NET_X) ? SAMPLE : IDLE;
      SAMPLE:  w_next = BALL_H == 11'(NET_X + 1) ? PREDICT : (w_below ? IDLE : SAMPLE);
      PREDICT: w_next = MOVE;
      MOVE:    w_next = w_below ? IDLE : (r_paddle == r_target ? HOLD : MOVE);
      HOLD:    w_next = w_below ? IDLE : HOLD;
      default: w_next = IDLE;
    endcase
    if (!ENABLE) w_next = IDLE;
  end
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_paddle   <= 9'd240;
      r_target   <= 9'd240;
      r_tracking <= 1'b0;
      r_arrived  <= 1'b0;
      r_v0       <= '0;
      r_v1       <= '0;
      r_dir      <= 1'b0;
    end else begin
      r_cnt      <= w_tick ? '0 : r_cnt + 1'b1;
      r_state    <= w_next;
      r_tracking <= w_next inside {SAMPLE, PREDICT, MOVE};
      r_arrived  <= w_next == HOLD;
      if (r_state == IDLE && w_next == SAMPLE) r_v0 <= BALL_V;
      if (r_state == SAMPLE) begin
        r_v1  <= BALL_V;
        r_dir <= BALL_V > r_v0;
      end
      if (r_state == PREDICT && w_next == MOVE) r_target <= w_tgt;
      if (r_state == MOVE && w_next == MOVE && w_tick) r_paddle <= r_paddle < r_target ? r_paddle + 9'd1 : r_paddle - 9'd1;
    end
  end
  assign POSITION = r_paddle[8:1];
  assign TARGET   = r_target;
  assign TRACKING = r_tracking;
  assign ARRIVED  = r_arrived;
endmodule

// File: tb/tb_ai_paddle_sequencer.sv
// tb_ai_paddle_sequencer: table vectors, directed corner sequences and random stimulus against a reference model
module tb_ai_paddle_sequencer;
  localparam int NET_X = 390, PADDLE_X = 770, FIELD_H = 474, PADDLE_HALF = 40, PADDLE_MAX = 395, STEP_DIV = 4;
  localparam int M_IDLE = 0, M_SAMPLE = 1, M_PREDICT = 2, M_MOVE = 3, M_HOLD = 4;
  logic CLOCK = 1'b0, RESET = 1'b1, ENABLE = 1'b0;
  logic [10:0] BALL_H = '0, BALL_V = '0;
  logic [7:0] POSITION;
  logic [8:0] TARGET;
  logic TRACKING, ARRIVED;
  int nvec = 0, nerr = 0;
  int m_mode, m_pad, m_tgt, m_cnt, m_v0, m_v1;
  typedef struct {int v0; int v1; int t;} vec_t;
  vec_t tbl[8];
  ai_paddle_sequencer #(.STEP_DIV(STEP_DIV)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .ENABLE(ENABLE), .BALL_H(BALL_H), .BALL_V(BALL_V),
    .POSITION(POSITION), .TARGET(TARGET), .TRACKING(TRACKING), .ARRIVED(ARRIVED)
  );
  always #5 CLOCK = ~CLOCK;
  function automatic int pred(int v0, int v1);
    int d = PADDLE_X - (NET_X + 1);
    bit down = v1 > v0;
    int y = down ? v1 + d : v1 - d;
    if (y < 0) y = -y;
    if (down && y > FIELD_H) y = 2 * FIELD_H - y;
    y -= PADDLE_HALF;
    return y < 0 ? 0 : (y > PADDLE_MAX ? PADDLE_MAX : y);
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model(input bit rst, input bit en, input int h, input int v);
    bit tick, below;
    if (rst) begin
      m_mode = M_IDLE; m_pad = 240; m_tgt = 240; m_cnt = 0;
      return;
    end
    tick = m_cnt == STEP_DIV - 1;
    m_cnt = tick ? 0 : m_cnt + 1;
    below = h < NET_X;
    if (!en) m_mode = M_IDLE;
    else case (m_mode)
      M_IDLE: if (h == NET_X) begin m_v0 = v; m_mode = M_SAMPLE; end
      M_SAMPLE: if (h == NET_X + 1) begin m_v1 = v; m_mode = M_PREDICT; end else if (below) m_mode = M_IDLE;
      M_PREDICT: begin m_tgt = pred(m_v0, m_v1); m_mode = M_MOVE; end
      M_MOVE: if (below) m_mode = M_IDLE; else if (m_pad == m_tgt) m_mode = M_HOLD; else if (tick) m_pad += (m_tgt > m_pad) ? 1 : -1;
      default: if (below) m_mode = M_IDLE;
    endcase
  endtask
  task automatic cyc(input bit rst, input bit en, input int h, input int v);
    RESET = rst; ENABLE = en; BALL_H = 11'(h); BALL_V = 11'(v);
    @(posedge CLOCK);
    model(rst, en, h, v);
    #1;
    chk("position", int'(POSITION), m_pad >> 1);
    chk("target", int'(TARGET), m_tgt);
    chk("tracking", int'(TRACKING), int'(m_mode inside {M_SAMPLE, M_PREDICT, M_MOVE}));
    chk("arrived", int'(ARRIVED), int'(m_mode == M_HOLD));
  endtask
  task automatic predict(input int v0, input int v1);
    cyc(0, 1, 100, 0);
    cyc(0, 1, NET_X, v0);
    cyc(0, 1, NET_X + 1, v1);
    cyc(0, 1, 500, v1);
  endtask
  task automatic wait_arrive(input int limit);
    for (int i = 0; i < limit && !ARRIVED; i++) cyc(0, 1, 500, 0);
    chk("arrive_timeout", int'(ARRIVED), 1);
  endtask
  initial begin
    tbl[0] = '{49, 50, 389};   tbl[1] = '{199, 200, 329};
    tbl[2] = '{101, 100, 239}; tbl[3] = '{401, 400, 0};
    tbl[4] = '{5, 0, 339};     tbl[5] = '{474, 474, 55};
    tbl[6] = '{10, 95, 395};   tbl[7] = '{300, 301, 228};
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst_pos", int'(POSITION), 120);
    chk("rst_target", int'(TARGET), 240);
    chk("rst_tracking", int'(TRACKING), 0);
    chk("rst_arrived", int'(ARRIVED), 0);
    for (int i = 0; i < 8; i++) begin
      predict(tbl[i].v0, tbl[i].v1);
      chk("tbl_target", int'(TARGET), tbl[i].t);
    end
    cyc(1, 0, 0, 0);
    predict(49, 50);
    chk("down_target", int'(TARGET), 389);
    wait_arrive(1000);
    chk("down_pos", int'(POSITION), 194);
    cyc(1, 0, 0, 0);
    predict(401, 400);
    chk("clamp_target", int'(TARGET), 0);
    wait_arrive(1200);
    chk("clamp_pos", int'(POSITION), 0);
    cyc(1, 0, 0, 0);
    predict(49, 50);
    for (int i = 0; i < 1000 && m_pad != 300; i++) cyc(0, 1, 500, 0);
    cyc(0, 1, 200, 0);
    chk("abort_tracking", int'(TRACKING), 0);
    for (int i = 0; i < 12; i++) cyc(0, 1, 200, 0);
    chk("abort_pos", int'(POSITION), 150);
    cyc(1, 0, 0, 0);
    predict(49, 50);
    for (int i = 0; i < 40; i++) cyc(0, 1, 500, 0);
    cyc(0, 0, NET_X, 0);
    chk("en_tracking", int'(TRACKING), 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, NET_X, 0);
    chk("en_frozen", int'(POSITION), 125);
    chk("en_target", int'(TARGET), 389);
    predict(49, 50);
    for (int i = 0; i < 30; i++) cyc(0, 1, 500, 0);
    cyc(1, 1, 500, 0);
    chk("midrst_pos", int'(POSITION), 120);
    chk("midrst_target", int'(TARGET), 240);
    chk("midrst_tracking", int'(TRACKING), 0);
    for (int i = 0; i < 4000; i++) begin
      int r = $urandom_range(0, 9);
      int h = r < 3 ? NET_X : r < 5 ? NET_X + 1 : r == 5 ? $urandom_range(0, NET_X - 1) : r == 6 ? $urandom_range(NET_X + 2, 2047) : 500;
      int v = $urandom_range(0, 1) ? $urandom_range(0, 600) : $urandom_range(0, 2047);
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 19) != 0, h, v);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
